// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory bundles for mem_access_unit
//
// mem_req_if : MEM-stage request and one-cycle completion response.
//    master = pipeline (requester), slave = mem_access_unit.
//    req_valid/req_ready handshake; req_write, req_size, req_signed,
//    req_addr, req_wdata describe the access; resp_valid pulses once per
//    request with resp_rdata/resp_error.
// mem_bus_if : byte-addressable data memory port.
//    master = mem_access_unit, slave = memory.
//    mem_address, mem_write_enable, mem_write_data out; mem_read_data in.

interface mem_req_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_error;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

interface mem_bus_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_write_enable;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   modport master (
      output mem_address, mem_write_enable, mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_address, mem_write_enable, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store controller with read-modify-write sub-word stores
//
// Accepts one request at a time from the MEM stage, drives the data memory
// port and returns sign/zero-extended load data with a one-cycle response.
// Sub-word stores read the containing word first, merge the new low bytes
// and write the whole word back.
//
// Ports:
//    i_clk      : clock, all state changes on the rising edge
//    i_reset_n  : asynchronous active-low reset
//    req_if     : mem_req_if.slave  (request handshake + response)
//    mem_if     : mem_bus_if.master (memory address/write/read data)
//
// Optional feature macro: ALIGN_CHECK_EN
//    defined   : misaligned halfword/word requests skip the memory and
//                complete immediately with resp_error=1, resp_rdata=0.
//    undefined : every address is accepted as an unaligned byte-lane access
//                and resp_error is always 0.

module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   mem_req_if.slave   req_if,
   mem_bus_if.master  mem_if
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic              r_write;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [15:0]       r_wdata_lo;
   logic [ADDR_W-1:0] r_mem_address;
   logic [31:0]       r_mem_write_data;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_error;

   logic              w_handshake;
   logic              w_misaligned;
   logic              w_word_access;
   logic [31:0]       w_load_data;
   logic [31:0]       w_merge_data;

   assign w_handshake = req_if.req_valid && (r_state == S_IDLE);

`ifdef ALIGN_CHECK_EN
   // Size 11 is treated as a word, so size[1] alone selects the word check.
   assign w_misaligned = ((req_if.req_size == 2'b01) && req_if.req_addr[0]) ||
                         (req_if.req_size[1] && (req_if.req_addr[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   // Sizes 10 and 11 are both full-word accesses.
   assign w_word_access = r_size[1];

   always_comb begin
      w_load_data = mem_if.mem_read_data;
      case (r_size)
         2'b00: w_load_data = {{24{r_signed & mem_if.mem_read_data[7]}},
                               mem_if.mem_read_data[7:0]};
         2'b01: w_load_data = {{16{r_signed & mem_if.mem_read_data[15]}},
                               mem_if.mem_read_data[15:0]};
         default: w_load_data = mem_if.mem_read_data;
      endcase
   end

   // Upper bytes of the word read during ISSUE are preserved.
   always_comb begin
      w_merge_data = mem_if.mem_read_data;
      if (r_size == 2'b00) begin
         w_merge_data = {mem_if.mem_read_data[31:8], r_wdata_lo[7:0]};
      end else begin
         w_merge_data = {mem_if.mem_read_data[31:16], r_wdata_lo};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state          <= S_IDLE;
         r_write          <= 1'b0;
         r_size           <= 2'b00;
         r_signed         <= 1'b0;
         r_wdata_lo       <= 16'h0000;
         r_mem_address    <= '0;
         r_mem_write_data <= 32'h0000_0000;
         r_resp_rdata     <= 32'h0000_0000;
         r_resp_error     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_handshake) begin
                  r_write    <= req_if.req_write;
                  r_size     <= req_if.req_size;
                  r_signed   <= req_if.req_signed;
                  r_wdata_lo <= req_if.req_wdata[15:0];
                  if (w_misaligned) begin
                     // Memory bus is left untouched on a rejected request.
                     r_resp_rdata <= 32'h0000_0000;
                     r_resp_error <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_mem_address    <= req_if.req_addr;
                     r_mem_write_data <= req_if.req_wdata;
                     r_state          <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_resp_error <= 1'b0;
               if (!r_write) begin
                  r_resp_rdata <= w_load_data;
                  r_state      <= S_DONE;
               end else if (w_word_access) begin
                  r_resp_rdata <= 32'h0000_0000;
                  r_state      <= S_DONE;
               end else begin
                  r_resp_rdata     <= 32'h0000_0000;
                  r_mem_write_data <= w_merge_data;
                  r_state          <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_if.req_ready  = (r_state == S_IDLE);
   assign req_if.resp_valid = (r_state == S_DONE);
   assign req_if.resp_rdata = r_resp_rdata;
   assign req_if.resp_error = r_resp_error;

   // Decoded from state so an asynchronous reset removes it immediately.
   assign mem_if.mem_write_enable = (r_state == S_WRITE) ||
                                    ((r_state == S_ISSUE) && r_write && w_word_access);
   assign mem_if.mem_address      = r_mem_address;
   assign mem_if.mem_write_data   = r_mem_write_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard testbench for mem_access_unit with a falling-edge data memory model

`timescale 1ns/1ps

module tb_mem_access_unit;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   mem_req_if #(.ADDR_W(32)) u_req ();
   mem_bus_if #(.ADDR_W(32)) u_mem ();

   mem_access_unit #(.ADDR_W(32)) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .req_if    (u_req),
      .mem_if    (u_mem)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_count = 0;
   int last_wr_cyc = -1;
   bit preloaded = 1'b0;

   logic [7:0] mem [0:1023];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: samples address/write on the falling edge and registers readData there.
   always @(negedge clk) begin
      logic [9:0] a;
      if (!preloaded) begin
         for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
         mem[10'h104] = 8'h11; mem[10'h105] = 8'h22;
         mem[10'h108] = 8'h11; mem[10'h109] = 8'h22;
         mem[10'h10A] = 8'h33; mem[10'h10B] = 8'h44;
         mem[10'h200] = 8'h01; mem[10'h201] = 8'h80;
         mem[10'h204] = 8'h7F;
         preloaded = 1'b1;
      end
      a = u_mem.mem_address[9:0];
      if (u_mem.mem_write_enable === 1'b1) begin
         mem[a]         = u_mem.mem_write_data[7:0];
         mem[a + 10'd1] = u_mem.mem_write_data[15:8];
         mem[a + 10'd2] = u_mem.mem_write_data[23:16];
         mem[a + 10'd3] = u_mem.mem_write_data[31:24];
         wr_count    = wr_count + 1;
         last_wr_cyc = cyc;
      end
      u_mem.mem_read_data <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every response pops the oldest expectation, in order.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && u_req.resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_resp: got rdata 0x%08h with no request outstanding",
                     u_req.resp_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_rdata"}, u_req.resp_rdata, e.rdata);
            check({e.name, "_error"}, {31'd0, u_req.resp_error}, {31'd0, e.err});
            check({e.name, "_cycle"}, cyc, e.due);
         end
      end
   end

   // lat = rising edges from the handshake edge to the one that enters DONE.
   task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat,
                        input bit hold, output int hs);
      int n;
      exp_t e;
      u_req.req_write  = wr;
      u_req.req_size   = sz;
      u_req.req_signed = sg;
      u_req.req_addr   = addr;
      u_req.req_wdata  = wd;
      u_req.req_valid  = 1'b1;
      n = 0;
      while (u_req.req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s_accept: got req_ready 0 for 20 cycles expected 1", name);
         u_req.req_valid = 1'b0;
         hs = -1;
      end else begin
         @(posedge clk); #1;
         hs = cyc;
         e.rdata = er; e.err = ee; e.due = hs + lat; e.name = name;
         exp_q.push_back(e);
         if (!hold) u_req.req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      int w0;
      reset_n          = 1'b0;
      u_req.req_valid  = 1'b0;
      u_req.req_write  = 1'b0;
      u_req.req_size   = 2'b00;
      u_req.req_signed = 1'b0;
      u_req.req_addr   = 32'h0;
      u_req.req_wdata  = 32'h0;

      #12;
      check("rst_req_ready",  {31'd0, u_req.req_ready},        32'd1);
      check("rst_resp_valid", {31'd0, u_req.resp_valid},       32'd0);
      check("rst_resp_rdata", u_req.resp_rdata,                32'd0);
      check("rst_resp_error", {31'd0, u_req.resp_error},       32'd0);
      check("rst_mem_addr",   u_mem.mem_address,               32'd0);
      check("rst_mem_we",     {31'd0, u_mem.mem_write_enable}, 32'd0);
      check("rst_mem_wdata",  u_mem.mem_write_data,            32'd0);

      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      w0 = wr_count;
      issue("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b0, hs);
      drain();
      check("st_word_wr_pulses", wr_count - w0, 32'd1);

      w0 = wr_count;
      issue("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b0, hs);
      drain();
      check("ld_word_wr_pulses", wr_count - w0, 32'd0);

      w0 = wr_count;
      issue("st_byte", 1'b1, 2'b00, 1'b0, 32'h100, 32'h12345655, 32'h0, 1'b0, 2, 1'b0, hs);
      drain();
      check("st_byte_wr_pulses", wr_count - w0, 32'd1);
      check("st_byte_wr_in_write", last_wr_cyc, hs + 1);

      issue("ld_after_byte", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBE55, 1'b0, 1, 1'b0, hs);
      drain();
      issue("ld_size3", 1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 32'hDEADBE55, 1'b0, 1, 1'b0, hs);
      drain();

      w0 = wr_count;
      issue("st_half", 1'b1, 2'b01, 1'b0, 32'h108, 32'h9999CAFE, 32'h0, 1'b0, 2, 1'b0, hs);
      drain();
      check("st_half_wr_pulses", wr_count - w0, 32'd1);
      issue("ld_after_half", 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 32'h4433CAFE, 1'b0, 1, 1'b0, hs);
      drain();

      issue("ld_half_s",  1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'hFFFF8001, 1'b0, 1, 1'b0, hs);
      drain();
      issue("ld_half_u",  1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h00008001, 1'b0, 1, 1'b0, hs);
      drain();
      issue("ld_byte_s7f", 1'b0, 2'b00, 1'b1, 32'h204, 32'h0, 32'h0000007F, 1'b0, 1, 1'b0, hs);
      drain();
      issue("ld_byte_s80", 1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 32'hFFFFFF80, 1'b0, 1, 1'b0, hs);
      drain();
      issue("ld_byte_u80", 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 32'h00000080, 1'b0, 1, 1'b0, hs);
      drain();

      w0 = wr_count;
`ifdef ALIGN_CHECK_EN
      issue("ld_unaligned", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 0, 1'b0, hs);
`else
      issue("ld_unaligned", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h2211DEAD, 1'b0, 1, 1'b0, hs);
`endif
      drain();
      check("ld_unaligned_wr_pulses", wr_count - w0, 32'd0);

      // req_valid stays high across three requests.
      w0 = wr_count;
      issue("b2b_ld_word", 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 32'h4433CAFE, 1'b0, 1, 1'b1, hs);
      issue("b2b_ld_byte", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h00000055, 1'b0, 1, 1'b1, hs);
      issue("b2b_st_word", 1'b1, 2'b10, 1'b0, 32'h10C, 32'h01020304, 32'h0, 1'b0, 1, 1'b0, hs);
      drain();
      check("b2b_wr_pulses", wr_count - w0, 32'd1);
      issue("ld_b2b_word", 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 32'h01020304, 1'b0, 1, 1'b0, hs);
      drain();

      // Reset while the byte-store write-back is pending.
      w0 = wr_count;
      u_req.req_write  = 1'b1;
      u_req.req_size   = 2'b00;
      u_req.req_signed = 1'b0;
      u_req.req_addr   = 32'h100;
      u_req.req_wdata  = 32'h000000AA;
      u_req.req_valid  = 1'b1;
      @(posedge clk); #1;
      u_req.req_valid  = 1'b0;
      @(posedge clk); #1;
      check("rst_wr_we_before", {31'd0, u_mem.mem_write_enable}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_wr_we_after",   {31'd0, u_mem.mem_write_enable}, 32'd0);
      check("rst_wr_req_ready",  {31'd0, u_req.req_ready},        32'd1);
      check("rst_wr_resp_valid", {31'd0, u_req.resp_valid},       32'd0);
      check("rst_wr_mem_addr",   u_mem.mem_address,               32'd0);
      @(negedge clk); #1;
      check("rst_wr_pulses", wr_count - w0, 32'd0);
      check("rst_wr_mem_word", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]},
            32'hDEADBE55);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBE55, 1'b0, 1, 1'b0, hs);
      drain();

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
